countdown_timer: RTL
====================

Name: countdown_timer

Overview:
- Two-digit BCD countdown timer (00-99 seconds) driven by an internal one-second prescaler.
- This is the down-counting counterpart of the team's free-running 0-9 seconds up-counter.
- Loaded with a start value, then counted down on start/stop pulses from debounced buttons.
- Digit outputs feed the seven-segment encoders; the done pulse drives an LED or buzzer.

Parameters:
- CYCLES_PER_SEC, 25000000, clock cycles per one-second tick (bench uses 4).

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_Load  input  1  single-cycle pulse; capture i_Load_Tens/i_Load_Ones.
- i_Load_Tens  input  4  BCD tens digit to load.
- i_Load_Ones  input  4  BCD ones digit to load.
- i_Start  input  1  single-cycle pulse; begin or resume counting.
- i_Stop  input  1  single-cycle pulse; pause counting.
- o_Tens  output  4  current tens digit, BCD.
- o_Ones  output  4  current ones digit, BCD.
- o_Running  output  1  high while in RUN.
- o_Done  output  1  one-cycle pulse when the count reaches 00.

Behaviour:
- Reset is one clock, asynchronous and active-low: i_Rst_L low forces the reset values immediately, independent of i_Clk.
- Reset values: state IDLE, o_Tens=0, o_Ones=0, o_Running=0, o_Done=0, prescaler=0.
- All outputs are registered.
- State IDLE (stopped, count loaded):
  - i_Start with count != 00 -> RUN, prescaler cleared.
  - i_Start with count == 00 is ignored.
- State RUN:
  - Prescaler increments each cycle.
  - At CYCLES_PER_SEC-1 the prescaler wraps to 0 and the count decrements.
  - First decrement occurs exactly CYCLES_PER_SEC cycles after the i_Start cycle.
  - i_Stop -> PAUSE.
- State PAUSE:
  - Prescaler and count held.
  - i_Start -> RUN, prescaler resumes from its held value.
- State DONE: entered when a decrement produces 00. Count stays 00; i_Start is ignored.
- i_Load in any state:
  - Next state IDLE, prescaler cleared, digits take the loaded values.
  - Any digit >9 is clamped to 9.
  - i_Load has priority over i_Start, i_Stop and any tick in the same cycle.
- i_Start and i_Stop in the same cycle: i_Stop wins (RUN->PAUSE; IDLE/PAUSE unchanged).
- i_Stop coinciding with a tick in RUN: the decrement is applied, then PAUSE.
- Decrement rule:
  - ones>0: ones-1.
  - ones==0: ones=9, tens-1.
  - Only invoked when count != 00; there is no wrap to 99.
- o_Done:
  - High for exactly one cycle, the same cycle o_Tens/o_Ones first show 00 and state shows DONE.
  - Never asserted by load or reset.
- o_Running = (state == RUN).
- Prescaler width is $clog2(CYCLES_PER_SEC). CYCLES_PER_SEC must be at least 2.

Decomposition:
- Shared package timer_pkg holds:
  - State enum (IDLE, RUN, PAUSE, DONE), 2 bits.
  - BCD_MAX = 9.
- One sub-module: tick_prescaler.
  - Inputs: clear and enable.
  - Output: one-cycle tick every CYCLES_PER_SEC enabled cycles.
  - Count held when enable is low.
- The BCD decrement and FSM stay in the top module.

Test Plan:
- Reset mid-run: load 05, start, drop i_Rst_L asynchronously between clock edges -> outputs return to 0/IDLE immediately, before the next i_Clk edge.
- CYCLES_PER_SEC=4: load 03, start at cycle 0 -> o_Ones = 2, 1, 0 at cycles 4, 8, 12; o_Done high only at cycle 12; o_Running falls at 12.
- Load 10, start -> after 1 tick o_Tens=0, o_Ones=9; load 0xF/0xC -> clamped to 99.
- Load 05, start, stop after 2 cycles, wait 20 cycles -> count still 05; start -> decrement to 04 two cycles later (prescaler held, not cleared).
- Same-cycle events:
  - i_Load with i_Start -> IDLE with the loaded value.
  - i_Start with i_Stop in IDLE -> stays IDLE.
  - Load 00 then start -> stays IDLE, no o_Done.
- In DONE, pulse i_Start -> no change; i_Load 02 -> IDLE showing 02, no o_Done.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types for the two-digit BCD countdown timer.
// Holds the FSM state encoding and digit clamp helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control and digit bundle between the button logic and the timer.
// master drives the pulses, slave is the timer itself.
interface countdown_timer_if;

  logic       i_Load;
  logic [3:0] i_Load_Tens;
  logic [3:0] i_Load_Ones;
  logic       i_Start;
  logic       i_Stop;
  logic [3:0] o_Tens;
  logic [3:0] o_Ones;
  logic       o_Running;
  logic       o_Done;

  modport master (
    output i_Load, i_Load_Tens, i_Load_Ones,
    output i_Start, i_Stop,
    input  o_Tens, o_Ones, o_Running, o_Done
  );

  modport slave (
    input  i_Load, i_Load_Tens, i_Load_Ones,
    input  i_Start, i_Stop,
    output o_Tens, o_Ones, o_Running, o_Done
  );

endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Divides the clock down to a one-cycle tick every CYCLES_PER_SEC
// enabled cycles; the count is frozen while enable is low.
module tick_prescaler #(
  parameter int CYCLES_PER_SEC = 25000000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = $clog2(CYCLES_PER_SEC);
  localparam logic [W-1:0] LAST = W'(CYCLES_PER_SEC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Two-digit BCD countdown timer with load, start/stop and done pulse.
// Digits and state are registered; the prescaler supplies the second tick.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 25000000
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  countdown_timer_if.slave bus
);

  state_t     state_q, state_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       done_q, done_d;
  logic       pre_clr;
  logic       pre_en;
  logic       tick;
  logic       nonzero;
  logic       last_one;

  assign nonzero  = (tens_q != 4'd0) || (ones_q != 4'd0);
  assign last_one = (tens_q == 4'd0) && (ones_q == 4'd1);
  assign pre_en   = (state_q == RUN);

  tick_prescaler #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_pre (
    .i_Clk  (i_Clk),
    .i_Rst_L(i_Rst_L),
    .clear  (pre_clr),
    .enable (pre_en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    pre_clr = 1'b0;
    if (bus.i_Load) begin
      state_d = IDLE;
      tens_d  = clamp_bcd(bus.i_Load_Tens);
      ones_d  = clamp_bcd(bus.i_Load_Ones);
      pre_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.i_Start && !bus.i_Stop && nonzero) begin
            state_d = RUN;
            pre_clr = 1'b1;
          end
        end
        RUN: begin
          // A tick is never lost to a same-cycle stop.
          if (tick) begin
            if (ones_q == 4'd0) begin
              ones_d = BCD_MAX;
              tens_d = tens_q - 4'd1;
            end else begin
              ones_d = ones_q - 4'd1;
            end
          end
          if (tick && last_one) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (bus.i_Stop) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (bus.i_Start && !bus.i_Stop) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      tens_q  <= 4'd0;
      ones_q  <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_Tens    = tens_q;
  assign bus.o_Ones    = ones_q;
  assign bus.o_Running = (state_q == RUN);
  assign bus.o_Done    = done_q;

endmodule
